sequence_generator: RTL and testbench

Serial pattern transmitter that produces the X bit stream consumed by the 101101 Moore/Mealy sequence detector. It loads a parallel frame and shifts it out MSB-first, one bit per clock, with optional seamless looping and abort. It also carries a golden expected-Z model, a match counter and a match pulse timed like the detector's Mealy output, so a bench or on-board self-test can compare against the detector directly.

---
 rtl/sequence_generator.sv | 157 +++++++++++++++
 tb/tb_sequence_generator.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sequence_generator.sv
// Serial frame transmitter feeding the 101101 sequence detector, with a golden
// Mealy expected-Z model, saturating match counter and loop/abort control.
module sequence_generator #(
    parameter int WIDTH   = 16,
    parameter int CNT_W   = 5,
    parameter int PAT_LEN = 6,
    parameter logic [PAT_LEN-1:0] PATTERN = 6'b101101
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] frame,
    input  logic [CNT_W-1:0] len,
    input  logic             repeat_en,
    input  logic             stop,
    output logic             X,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic             exp_z,
    output logic [7:0]       match_cnt
);

    localparam int SENT_W = $clog2(PAT_LEN + 1);
    localparam logic [SENT_W-1:0] SENT_MAX = SENT_W'(PAT_LEN);
    localparam logic [SENT_W-1:0] SENT_THR = SENT_W'(PAT_LEN - 1);
    localparam logic [CNT_W-1:0]  LEN_MAX  = CNT_W'(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   frame_q, frame_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic [PAT_LEN-2:0] hist_q, hist_d;
    logic [SENT_W-1:0]  sent_q, sent_d;
    logic [7:0]         match_q, match_d;

    logic [WIDTH-1:0]   shifted_s;
    logic [PAT_LEN-1:0] window_s;
    logic [CNT_W-1:0]   len_eff_s;
    logic               x_s;
    logic               valid_s;
    logic               exp_z_s;

    // Serial bit selection and golden Mealy match on the bit leaving this cycle
    always_comb begin
        x_s       = 1'b0;
        valid_s   = 1'b0;
        shifted_s = frame_q >> idx_q;
        if (state_q == ST_SEND) begin
            x_s     = shifted_s[0];
            valid_s = 1'b1;
        end else begin
            x_s     = 1'b0;
            valid_s = 1'b0;
        end
        window_s = {hist_q, x_s};
        // sent_q excludes the current bit, so PAT_LEN-1 prior bits complete a window
        exp_z_s  = valid_s & (window_s == PATTERN) & (sent_q >= SENT_THR);
        if (len > LEN_MAX) begin
            len_eff_s = LEN_MAX;
        end else begin
            len_eff_s = len;
        end
    end

    // Next-state logic for the transmit FSM and its datapath
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        len_d   = len_q;
        idx_d   = idx_q;
        hist_d  = hist_q;
        sent_d  = sent_q;
        match_d = match_q;
        if (exp_z_s && (match_q != 8'hFF)) begin
            match_d = match_q + 8'd1;
        end else begin
            match_d = match_q;
        end
        case (state_q)
            ST_IDLE: begin
                if (start && (len != {CNT_W{1'b0}})) begin
                    frame_d = frame;
                    len_d   = len_eff_s;
                    idx_d   = len_eff_s - CNT_W'(1);
                    hist_d  = '0;
                    sent_d  = '0;
                    match_d = 8'd0;
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                hist_d = window_s[PAT_LEN-2:0];
                if (sent_q != SENT_MAX) begin
                    sent_d = sent_q + SENT_W'(1);
                end else begin
                    sent_d = sent_q;
                end
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (idx_q == {CNT_W{1'b0}}) begin
                    // Looping keeps history so cross-boundary patterns still match
                    if (repeat_en) begin
                        idx_d = len_q - CNT_W'(1);
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    idx_d = idx_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            frame_q <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            hist_q  <= '0;
            sent_q  <= '0;
            match_q <= 8'd0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            hist_q  <= hist_d;
            sent_q  <= sent_d;
            match_q <= match_d;
        end
    end

    assign X         = x_s;
    assign valid     = valid_s;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign exp_z     = exp_z_s;
    assign match_cnt = match_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Directed self-checking bench for sequence_generator: a vector table for the
// single and overlapping frames, plus hand-written multi-cycle corner cases.
module tb_sequence_generator;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] frame;
    logic [4:0]  len;
    logic        repeat_en;
    logic        stop;
    logic        x_o;
    logic        valid_o;
    logic        busy_o;
    logic        done_o;
    logic        exp_z_o;
    logic [7:0]  match_cnt_o;

    int checks   = 0;
    int failures = 0;

    sequence_generator dut (
        .clk       (clk),
        .reset     (rst_n),
        .start     (start),
        .frame     (frame),
        .len       (len),
        .repeat_en (repeat_en),
        .stop      (stop),
        .X         (x_o),
        .valid     (valid_o),
        .busy      (busy_o),
        .done      (done_o),
        .exp_z     (exp_z_o),
        .match_cnt (match_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        start;
        logic [15:0] frame;
        logic [4:0]  len;
        logic        x;
        logic        valid;
        logic        busy;
        logic        done;
        logic        z;
        logic [7:0]  mc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic s, logic [15:0] f, logic [4:0] l,
                                logic x, logic v, logic b, logic d, logic z,
                                logic [7:0] mc);
        vec_t t;
        t.rst_n = r; t.start = s; t.frame = f; t.len = l;
        t.x = x; t.valid = v; t.busy = b; t.done = d; t.z = z; t.mc = mc;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] outs();
        return {19'd0, x_o, valid_o, busy_o, done_o, exp_z_o, match_cnt_o};
    endfunction

    // Run one non-repeating frame already started at the preceding edge.
    // inj_cycle>0 pulses a spurious start with different data in that cycle.
    task automatic expect_frame(input string name, input logic [15:0] f, input int nbits,
                                input logic chk_z, input logic [31:0] zmask,
                                input int inj_cycle);
        for (int n = 1; n <= nbits + 2; n++) begin
            if (n <= nbits) begin
                chk({name, "_x"}, {31'd0, x_o}, {31'd0, f[nbits - n]});
                chk({name, "_valid"}, {31'd0, valid_o}, 32'd1);
                if (chk_z) chk({name, "_z"}, {31'd0, exp_z_o}, {31'd0, zmask[n]});
            end else if (n == nbits + 1) begin
                chk({name, "_done"}, {30'd0, valid_o, done_o}, 32'd1);
            end else begin
                chk({name, "_idle"}, {30'd0, busy_o, done_o}, 32'd0);
            end
            start = 1'b0;
            if (n == inj_cycle) begin
                start = 1'b1;
                frame = 16'hFFFF;
                len   = 5'd16;
            end
            step();
        end
    endtask

    logic [5:0] pat;
    logic [7:0] mc_exp;
    logic       z_exp;
    logic       v_exp;

    initial begin
        pat       = 6'b101101;
        rst_n     = 1'b0;
        start     = 1'b0;
        frame     = 16'h0000;
        len       = 5'd0;
        repeat_en = 1'b0;
        stop      = 1'b0;

        // Case 1: reset then single 101101 frame
        vecs.push_back(mk(0, 0, 16'h0000, 5'd0, 0, 0, 0, 0, 0, 8'd0));
        vecs.push_back(mk(0, 0, 16'h0000, 5'd0, 0, 0, 0, 0, 0, 8'd0));
        vecs.push_back(mk(1, 1, 16'h002D, 5'd6, 1, 1, 1, 0, 0, 8'd0));
        vecs.push_back(mk(1, 0, 16'h002D, 5'd6, 0, 1, 1, 0, 0, 8'd0));
        vecs.push_back(mk(1, 0, 16'h002D, 5'd6, 1, 1, 1, 0, 0, 8'd0));
        vecs.push_back(mk(1, 0, 16'h002D, 5'd6, 1, 1, 1, 0, 0, 8'd0));
        vecs.push_back(mk(1, 0, 16'h002D, 5'd6, 0, 1, 1, 0, 0, 8'd0));
        vecs.push_back(mk(1, 0, 16'h002D, 5'd6, 1, 1, 1, 0, 1, 8'd0));
        vecs.push_back(mk(1, 0, 16'h002D, 5'd6, 0, 0, 1, 1, 0, 8'd1));
        vecs.push_back(mk(1, 0, 16'h002D, 5'd6, 0, 0, 0, 0, 0, 8'd1));
        // Case 2: overlapping 101101101, matches in cycles 6 and 9
        vecs.push_back(mk(1, 1, 16'h016D, 5'd9, 1, 1, 1, 0, 0, 8'd0));
        vecs.push_back(mk(1, 0, 16'h016D, 5'd9, 0, 1, 1, 0, 0, 8'd0));
        vecs.push_back(mk(1, 0, 16'h016D, 5'd9, 1, 1, 1, 0, 0, 8'd0));
        vecs.push_back(mk(1, 0, 16'h016D, 5'd9, 1, 1, 1, 0, 0, 8'd0));
        vecs.push_back(mk(1, 0, 16'h016D, 5'd9, 0, 1, 1, 0, 0, 8'd0));
        vecs.push_back(mk(1, 0, 16'h016D, 5'd9, 1, 1, 1, 0, 1, 8'd0));
        vecs.push_back(mk(1, 0, 16'h016D, 5'd9, 1, 1, 1, 0, 0, 8'd1));
        vecs.push_back(mk(1, 0, 16'h016D, 5'd9, 0, 1, 1, 0, 0, 8'd1));
        vecs.push_back(mk(1, 0, 16'h016D, 5'd9, 1, 1, 1, 0, 1, 8'd1));
        vecs.push_back(mk(1, 0, 16'h016D, 5'd9, 0, 0, 1, 1, 0, 8'd2));
        vecs.push_back(mk(1, 0, 16'h016D, 5'd9, 0, 0, 0, 0, 0, 8'd2));
        // Case 4a: start with len==0 is ignored and leaves match_cnt alone
        vecs.push_back(mk(1, 1, 16'hFFFF, 5'd0, 0, 0, 0, 0, 0, 8'd2));
        vecs.push_back(mk(1, 0, 16'hFFFF, 5'd0, 0, 0, 0, 0, 0, 8'd2));

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n = vecs[i].rst_n;
            start = vecs[i].start;
            frame = vecs[i].frame;
            len   = vecs[i].len;
            step();
            chk($sformatf("vec%0d", i), outs(),
                {19'd0, vecs[i].x, vecs[i].valid, vecs[i].busy, vecs[i].done,
                 vecs[i].z, vecs[i].mc});
        end

        // Case 3: looping frame, stop asserted in cycle 14
        start = 1'b1; frame = 16'h002D; len = 5'd6; repeat_en = 1'b1;
        step();
        start = 1'b0;
        mc_exp = 8'd0;
        for (int n = 1; n <= 16; n++) begin
            v_exp = (n <= 14);
            z_exp = v_exp && (n >= 6) && (n % 3 == 0);
            chk($sformatf("rep_c%0d", n), outs(),
                {19'd0, v_exp & pat[5 - ((n - 1) % 6)], v_exp, v_exp, 1'b0, z_exp, mc_exp});
            if (z_exp) mc_exp = mc_exp + 8'd1;
            stop = (n == 14);
            step();
        end
        chk("rep_stop_mc", {24'd0, match_cnt_o}, 32'd3);
        repeat_en = 1'b0;

        // Case 4b: spurious start mid-frame does not disturb the frame
        start = 1'b1; frame = 16'h002D; len = 5'd6;
        step();
        expect_frame("midstart", 16'h002D, 6, 1'b1, 32'h40, 3);

        // Case 4c: len 31 is clamped to 16 bits
        start = 1'b1; frame = 16'hA5A5; len = 5'd31;
        step();
        expect_frame("clamp", 16'hA5A5, 16, 1'b0, 32'h0, 0);

        // Case 5: reset mid-frame then a clean frame
        start = 1'b1; frame = 16'h002D; len = 5'd6;
        step();
        start = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        chk("rst_mid", outs(), 32'd0);
        rst_n = 1'b1;
        start = 1'b1;
        step();
        expect_frame("post_rst", 16'h002D, 6, 1'b1, 32'h40, 0);
        chk("post_rst_mc", {24'd0, match_cnt_o}, 32'd1);

        // Case 6: match_cnt saturates at 255 while exp_z keeps pulsing
        start = 1'b1; frame = 16'h002D; len = 5'd6; repeat_en = 1'b1;
        step();
        start = 1'b0;
        mc_exp = 8'd0;
        for (int n = 1; n <= 820; n++) begin
            z_exp = (n >= 6) && (n % 3 == 0);
            chk($sformatf("sat_x%0d", n), {31'd0, x_o}, {31'd0, pat[5 - ((n - 1) % 6)]});
            chk($sformatf("sat_z%0d", n), {31'd0, exp_z_o}, {31'd0, z_exp});
            if (z_exp && mc_exp != 8'hFF) mc_exp = mc_exp + 8'd1;
            step();
        end
        chk("sat_mc", {24'd0, match_cnt_o}, {24'd0, mc_exp});
        chk("sat_255", {24'd0, match_cnt_o}, 32'd255);
        stop = 1'b1;
        step();
        stop = 1'b0;
        repeat_en = 1'b0;
        chk("sat_stopped", {29'd0, valid_o, busy_o, done_o}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
